// File: rtl/cam_capture_if.sv
// cam_capture_if: camera byte bus in and frame-buffer write port out of cam_capture.
interface cam_capture_if #(
    parameter int ADDR_W = 17
);
    logic              cam_pclk_in;
    logic              cam_vsync_in;
    logic              cam_href_in;
    logic [7:0]        cam_data_in;
    logic [ADDR_W-1:0] pixel_addr_out;
    logic [15:0]       pixel_data_out;
    logic              pixel_valid_out;
    logic              frame_done_out;
    logic              busy_out;

    modport slave (
        input  cam_pclk_in, cam_vsync_in, cam_href_in, cam_data_in,
        output pixel_addr_out, pixel_data_out, pixel_valid_out, frame_done_out, busy_out
    );

    modport master (
        output cam_pclk_in, cam_vsync_in, cam_href_in, cam_data_in,
        input  pixel_addr_out, pixel_data_out, pixel_valid_out, frame_done_out, busy_out
    );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: deserializes the 8-bit camera bus into RGB565 frame-buffer writes.
module cam_capture #(
    parameter int CAM_W  = 240,
    parameter int CAM_H  = 320,
    parameter int ADDR_W = 17
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         enable_in,
    cam_capture_if.slave bus
);
    localparam int CW = $clog2(CAM_W + 1);
    localparam int RW = $clog2(CAM_H + 1);

    typedef enum logic {S_WAIT, S_FRAME} state_t;
    state_t state, state_nx;

    logic              a_pclk, b_pclk, a_vsync, a_href;
    logic [7:0]        a_data, hi;
    logic              vsync_q, href_q, byte_phase;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] row_base;
    logic              rise, frame_start, frame_end, line_end, in_byte;

    // camera events are taken from stage A only on the single cycle pclk is seen rising
    assign rise        = a_pclk & ~b_pclk;
    assign frame_start = rise && state == S_WAIT && vsync_q && !a_vsync && enable_in;
    assign frame_end   = rise && state == S_FRAME && !vsync_q && a_vsync;
    assign line_end    = rise && state == S_FRAME && href_q && !a_href;
    assign in_byte     = rise && state == S_FRAME && a_href;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_WAIT;
        else state <= state_nx;
    end

    always_comb state_nx = frame_start ? S_FRAME : frame_end ? S_WAIT : state;

    always_comb bus.busy_out = (state == S_FRAME);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_pclk              <= 1'b0;
            b_pclk              <= 1'b0;
            a_vsync             <= 1'b0;
            a_href              <= 1'b0;
            a_data              <= '0;
            vsync_q             <= 1'b0;
            href_q              <= 1'b0;
            byte_phase          <= 1'b0;
            hi                  <= '0;
            col                 <= '0;
            row                 <= '0;
            row_base            <= '0;
            bus.pixel_valid_out <= 1'b0;
            bus.pixel_addr_out  <= '0;
            bus.pixel_data_out  <= '0;
            bus.frame_done_out  <= 1'b0;
        end else begin
            a_pclk              <= bus.cam_pclk_in;
            a_vsync             <= bus.cam_vsync_in;
            a_href              <= bus.cam_href_in;
            a_data              <= bus.cam_data_in;
            b_pclk              <= a_pclk;
            bus.pixel_valid_out <= 1'b0;
            bus.frame_done_out  <= frame_end;
            if (rise) begin
                vsync_q <= a_vsync;
                href_q  <= a_href;
            end
            if (frame_start) begin
                col        <= '0;
                row        <= '0;
                row_base   <= '0;
                byte_phase <= 1'b0;
            end
            if (in_byte) begin
                byte_phase <= ~byte_phase;
                if (!byte_phase) hi <= a_data;
            end
            if (in_byte && byte_phase) begin
                if (col < CW'(CAM_W)) col <= col + 1'b1;
                if (col < CW'(CAM_W) && row < RW'(CAM_H)) begin
                    bus.pixel_valid_out <= 1'b1;
                    bus.pixel_addr_out  <= row_base + ADDR_W'(col);
                    bus.pixel_data_out  <= {hi, a_data};
                end
            end
            // row_base stops with row so it can never run past the buffer
            if (line_end) begin
                col        <= '0;
                byte_phase <= 1'b0;
                if (col != '0 && row < RW'(CAM_H)) begin
                    row      <= row + 1'b1;
                    row_base <= row_base + ADDR_W'(CAM_W);
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized camera frames checked against a row-major pixel model.
module tb_cam_capture;
    localparam int W = 12;
    localparam int H = 8;
    localparam int AW = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    int checks = 0, errors = 0;
    int exp_done = 0, got_done = 0;
    int nstrobe = 0, max_addr = -1, first_addr = -1, mrow = 0;
    logic [31:0] exp_q[$];
    bit tog = 0, prev_done = 0;

    cam_capture_if #(.ADDR_W(AW)) bus();

    cam_capture #(.CAM_W(W), .CAM_H(H), .ADDR_W(AW)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .enable_in(enable),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_n) begin
            chk("reset_outputs", {bus.pixel_valid_out, bus.frame_done_out, bus.busy_out,
                                  bus.pixel_addr_out, bus.pixel_data_out}, 64'd0);
            prev_done = 0;
        end else begin
            if (bus.frame_done_out) begin
                got_done++;
                chk("done_pulse_width", prev_done, 0);
            end
            prev_done = bus.frame_done_out;
            if (bus.pixel_valid_out) begin
                nstrobe++;
                if (int'(bus.pixel_addr_out) > max_addr) max_addr = int'(bus.pixel_addr_out);
                if (first_addr < 0) first_addr = int'(bus.pixel_addr_out);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_strobe: addr %0d data %0h with nothing expected",
                             bus.pixel_addr_out, bus.pixel_data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_addr", bus.pixel_addr_out, e[31:16]);
                    chk("pixel_data", bus.pixel_data_out, e[15:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic v, input logic h, input logic [7:0] d);
        @(negedge clk);
        bus.cam_vsync_in = v;
        bus.cam_href_in  = h;
        bus.cam_data_in  = d;
        bus.cam_pclk_in  = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus.cam_pclk_in = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    // expected pixels: byte pairs of a line, row index counts only lines holding a pixel
    task automatic send_line(input int nb, input bit cap, input bit vs_end);
        logic [7:0] b[$];
        for (int i = 0; i < nb; i++) b.push_back(8'($urandom));
        if (cap && nb / 2 > 0) begin
            for (int k = 0; k < nb / 2; k++)
                if (k < W && mrow < H) exp_q.push_back({16'(mrow * W + k), b[2*k], b[2*k+1]});
            mrow++;
        end
        foreach (b[i]) begin
            if (tog && $urandom_range(0, 9) == 0) enable = ~enable;
            send_byte(1'b0, 1'b1, b[i]);
        end
        send_byte(vs_end, 1'b0, 8'($urandom));
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        chk("leftover_pixels", exp_q.size(), 0);
        chk("frame_done_count", got_done, exp_done);
        chk("busy_after_frame", bus.busy_out, 0);
    endtask

    task automatic frame(input int nlines, input int nb, input bit en, input bit t);
        bit sim = 0;
        enable = en;
        tog = 0;
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        chk("busy_in_frame", bus.busy_out, en);
        mrow = 0;
        nstrobe = 0;
        max_addr = -1;
        first_addr = -1;
        tog = t;
        for (int l = 0; l < nlines; l++) begin
            sim = (l == nlines - 1) && ($urandom_range(0, 1) == 1);
            send_line(nb < 0 ? int'($urandom_range(0, 2 * W + 5)) : nb, en, sim);
        end
        tog = 0;
        if (!sim) send_byte(1'b1, 1'b0, 8'h00);
        if (en) exp_done++;
        settle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        bus.cam_pclk_in  = 1'b0;
        bus.cam_vsync_in = 1'b1;
        bus.cam_href_in  = 1'b0;
        bus.cam_data_in  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_valid", bus.pixel_valid_out, 0);
        chk("reset_busy", bus.busy_out, 0);
        rst_n = 1'b1;

        enable = 1'b1;
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        exp_q.push_back({16'd0, 16'hF81F});
        bus.cam_href_in = 1'b1;
        bus.cam_data_in = 8'hF8;
        bus.cam_pclk_in = 1'b1;
        repeat (3) @(negedge clk);
        bus.cam_pclk_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.cam_data_in = 8'h1F;
        bus.cam_pclk_in = 1'b1;
        @(posedge clk); #1;
        chk("latency_not_early", bus.pixel_valid_out, 0);
        @(posedge clk); #1;
        chk("latency_valid", bus.pixel_valid_out, 1);
        chk("latency_addr", bus.pixel_addr_out, 0);
        chk("latency_data", bus.pixel_data_out, 16'hF81F);
        @(posedge clk); #1;
        chk("latency_single", bus.pixel_valid_out, 0);
        @(negedge clk);
        bus.cam_pclk_in = 1'b0;
        send_byte(1'b0, 1'b0, 8'h00);
        send_byte(1'b1, 1'b0, 8'h00);
        exp_done++;
        settle();

        frame(H, 2 * W, 1, 0);
        chk("nominal_count", nstrobe, W * H);
        chk("nominal_max_addr", max_addr, W * H - 1);

        frame(H + 2, 2 * W + 4, 1, 0);
        chk("clip_count", nstrobe, W * H);
        chk("clip_max_addr", max_addr, W * H - 1);

        frame(6, 5, 1, 0);
        chk("odd_count", nstrobe, 12);
        chk("odd_max_addr", max_addr, 5 * W + 1);

        frame(H, 2 * W, 0, 0);
        chk("disabled_count", nstrobe, 0);
        frame(H, 2 * W, 1, 1);
        chk("toggle_count", nstrobe, W * H);

        enable = 1'b1;
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b1, 1'b0, 8'h00);
        send_byte(1'b0, 1'b0, 8'h00);
        mrow = 0;
        for (int l = 0; l < 3; l++) send_line(2 * W, 1, 0);
        for (int k = 0; k < 3; k++) exp_q.push_back({16'(3 * W + k), 8'(k + 1), ~8'(k + 1)});
        for (int k = 0; k < 3; k++) begin
            send_byte(1'b0, 1'b1, 8'(k + 1));
            send_byte(1'b0, 1'b1, ~8'(k + 1));
        end
        send_byte(1'b0, 1'b1, 8'h55);
        repeat (3) @(negedge clk);
        chk("pre_reset_addr", bus.pixel_addr_out, 3 * W + 2);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_reset_valid", bus.pixel_valid_out, 0);
        chk("async_reset_addr", bus.pixel_addr_out, 0);
        chk("async_reset_data", bus.pixel_data_out, 0);
        chk("async_reset_busy", bus.busy_out, 0);
        bus.cam_pclk_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nstrobe = 0;
        for (int l = 0; l < 4; l++) send_line(2 * W, 0, 0);
        send_byte(1'b1, 1'b0, 8'h00);
        settle();
        chk("ghost_strobes", nstrobe, 0);
        frame(H, 2 * W, 1, 0);
        chk("restart_first_addr", first_addr, 0);
        chk("restart_count", nstrobe, W * H);

        for (int f = 0; f < 10; f++)
            frame($urandom_range(0, H + 2), -1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
